// File: rtl/reference_fetcher.sv
// Read initiator for the reference sample buffer: sweeps addresses, collects I/Q returns in a
// 4-entry skid FIFO and streams them out. Define REFERENCE_FETCHER_LOOP_EN for continuous sweeping.
module reference_fetcher #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [index_bits-1:0] m_axi_raddr,
  output logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  s_axi_rready,
  input  logic                  s_axi_rvalid,
  input  logic [i_bits-1:0]     s_i,
  input  logic [q_bits-1:0]     s_q,
  output logic [i_bits-1:0]     out_i,
  output logic [q_bits-1:0]     out_q,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow
);

  localparam int W = 1 + i_bits + q_bits;
  localparam logic [index_bits-1:0] last_addr = index_bits'(buffer_length - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [index_bits-1:0] raddr;
  logic [W-1:0]          mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            count;
  logic [2:0]            in_flight;
  logic                  tag_d1;
  logic                  tag_d2;
  logic                  room;
  logic                  issue;
  logic                  ret;
  logic                  dec;
  logic                  push;
  logic                  pop;

  // Handshakes: a request transfers in any cycle with m_axi_rvalid high (it is only raised while
  // s_axi_rready is high); a return is taken whenever s_axi_rvalid is high while m_axi_rready is
  // high; a stream word transfers when out_valid && out_ready, and the head holds until then.
  assign busy         = (state != IDLE);
  assign m_axi_rready = busy;
  assign room         = ({1'b0, count} + {1'b0, in_flight}) < 4'd4;
  assign issue        = (state == ISSUE) && s_axi_rready && room;
  assign m_axi_rvalid = issue;
  assign m_axi_raddr  = raddr;

  assign ret       = s_axi_rvalid && m_axi_rready;
  assign dec       = ret && (in_flight != 3'd0);
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a return when the head leaves in the same cycle.
  assign push      = ret && ((count != 3'd4) || pop);

  assign {out_last, out_i, out_q} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            raddr <= '0;
          end
        end
        ISSUE: begin
          if (issue) raddr <= (raddr == last_addr) ? '0 : raddr + index_bits'(1);
`ifdef REFERENCE_FETCHER_LOOP_EN
          if (start) state <= DRAIN;
`else
          if (issue && (raddr == last_addr)) state <= DRAIN;
`endif
        end
        DRAIN: begin
          if ((count == 3'd0) && (in_flight == 3'd0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The responder latency is fixed at two cycles, so the last-sample tag rides a matching delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_d1    <= 1'b0;
      tag_d2    <= 1'b0;
      in_flight <= 3'd0;
    end else begin
      tag_d1 <= issue && (raddr == last_addr);
      tag_d2 <= tag_d1;
      case ({issue, dec})
        2'b10:   in_flight <= in_flight + 3'd1;
        2'b01:   in_flight <= in_flight - 3'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) mem[k] <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {tag_d2, s_i, s_q};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ret && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reference_fetcher.sv
// Bench for reference_fetcher: 2-cycle responder model, stream monitor and a queue-based
// reference of the expected sweep (sample k = buffer[k mod length], last on k mod length = length-1).
module tb_reference_fetcher;

  localparam int L = 10;
  localparam int W = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  m_axi_raddr;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        s_axi_rready = 1'b0;
  logic        s_axi_rvalid = 1'b0;
  logic [11:0] s_i = '0;
  logic [11:0] s_q = '0;
  logic [11:0] out_i;
  logic [11:0] out_q;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        overflow;

  reference_fetcher #(.buffer_length(L), .index_bits(4), .i_bits(12), .q_bits(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid), .s_i(s_i), .s_q(s_q),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [11:0] buf_i [L];
  logic [11:0] buf_q [L];

  int rr_mode = 0;
  bit or_en = 1'b1;
  bit or_rand = 1'b0;
  bit inject = 1'b0;
  bit tog = 1'b0;
  bit d1_v = 1'b0;
  bit d2_v = 1'b0;
  logic [3:0] d1_a = '0;
  logic [3:0] d2_a = '0;

  int cycle = 0;
  int req_cnt = 0;
  int viol = 0;
  int hold_viol = 0;
  int first_valid = -1;
  int first_pop = -1;
  int last_pop = -1;
  int busy_fall = -1;
  int first_req_addr = -1;
  bit prev_busy = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_word = '0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  int n_assert = 0;
  int n_fail = 0;

  // Responder, ready drivers and stream monitor: inputs change on the falling edge, outputs are
  // observed 1 ns later, well away from the rising edge.
  always @(negedge clk) begin
    if (inject) begin
      s_axi_rvalid = 1'b1;
      s_i = 12'h7ff;
      s_q = 12'h800;
      inject = 1'b0;
    end else begin
      s_axi_rvalid = d2_v;
      s_i = (d2_a < L) ? buf_i[d2_a] : 12'h0;
      s_q = (d2_a < L) ? buf_q[d2_a] : 12'h0;
    end
    d2_v = d1_v;
    d2_a = d1_a;
    tog = ~tog;
    case (rr_mode)
      0:       s_axi_rready = 1'b1;
      1:       s_axi_rready = tog;
      default: s_axi_rready = ($urandom_range(0, 1) == 1);
    endcase
    out_ready = or_en && (!or_rand || ($urandom_range(0, 1) == 1));
    #1;
    cycle++;
    d1_v = m_axi_rvalid;
    d1_a = m_axi_raddr;
    if (m_axi_rvalid) begin
      req_cnt++;
      if (first_req_addr < 0) first_req_addr = int'(m_axi_raddr);
      if (!s_axi_rready || (m_axi_raddr >= L)) viol++;
    end
    if (prev_stall && (!out_valid || ({out_last, out_i, out_q} !== prev_word))) hold_viol++;
    prev_stall = out_valid && !out_ready;
    prev_word = {out_last, out_i, out_q};
    if (out_valid && (first_valid < 0)) first_valid = cycle;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_i, out_q});
      if (first_pop < 0) first_pop = cycle;
      last_pop = cycle;
    end
    if (prev_busy && !busy) busy_fall = cycle;
    prev_busy = busy;
  end

  // ---------------- reference model ----------------
  function automatic void model_sweep(input int n);
    exp_q.delete();
    for (int j = 0; j < n; j++) begin
      int k;
      k = j % L;
      exp_q.push_back({(k == L - 1), buf_i[k], buf_q[k]});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int k = 0; k < L; k++) begin
      buf_i[k] = 12'($urandom);
      buf_q[k] = 12'($urandom);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    first_valid = -1;
    first_pop = -1;
    last_pop = -1;
    busy_fall = -1;
    first_req_addr = -1;
    req_cnt = 0;
    viol = 0;
    hold_viol = 0;
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    #2;
    s = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy === 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #2;
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic wait_samples(input int want, input int budget, input string name);
    int n;
    n = 0;
    while ((got_q.size() < want) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #2;
    n_assert++;
    if (got_q.size() < want) begin
      n_fail++;
      $display("FAIL %s_sample_timeout: got %0d samples, required %0d", name, got_q.size(), want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_assert++;
    if ({busy, out_valid, out_last, overflow, m_axi_rvalid, m_axi_rready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy/valid/last/ovf/rvalid/rready=%b, required 000000",
               {busy, out_valid, out_last, overflow, m_axi_rvalid, m_axi_rready});
    end
    n_assert++;
    if ({m_axi_raddr, out_i, out_q} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_data: raddr=%0d out_i=%h out_q=%h, required 0", m_axi_raddr, out_i, out_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_sweep();
    int s;
    for (int k = 0; k < L; k++) begin
      buf_i[k] = 12'(k);
      buf_q[k] = 12'(-k);
    end
    rr_mode = 0; or_en = 1'b1; or_rand = 1'b0;
    clear_mon();
    pulse_start(s);
    wait_idle(100, "single");
    model_sweep(L);
    n_assert++;
    if (got_q.size() != L) begin
      n_fail++;
      $display("FAIL single_count: got %0d samples, required %0d", got_q.size(), L);
    end
    for (int k = 0; k < L && k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL single_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_assert++;
    if (first_valid - s != 4) begin
      n_fail++;
      $display("FAIL single_latency: start-to-valid %0d cycles, required 4", first_valid - s);
    end
    n_assert++;
    if (last_pop - first_pop != L - 1) begin
      n_fail++;
      $display("FAIL single_throughput: pops span %0d cycles, required %0d", last_pop - first_pop, L - 1);
    end
    n_assert++;
    if (busy_fall - last_pop != 2) begin
      n_fail++;
      $display("FAIL single_busy_fall: busy fell %0d cycles after last pop, required 2", busy_fall - last_pop);
    end
    n_assert++;
    if ((overflow !== 1'b0) || (viol != 0)) begin
      n_fail++;
      $display("FAIL single_clean: overflow=%b violations=%0d, required 0/0", overflow, viol);
    end
  endtask

  task automatic test_backpressure();
    int s;
    fill_random();
    rr_mode = 0; or_en = 1'b0; or_rand = 1'b0;
    clear_mon();
    pulse_start(s);
    repeat (20) @(negedge clk);
    #2;
    n_assert++;
    if (req_cnt != 4) begin
      n_fail++;
      $display("FAIL bp_requests: %0d requests while stalled, required 4", req_cnt);
    end
    n_assert++;
    if ({out_valid, overflow, m_axi_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_full: valid/ovf/rvalid=%b, required 100", {out_valid, overflow, m_axi_rvalid});
    end
    or_en = 1'b1;
    wait_idle(100, "bp");
    model_sweep(L);
    n_assert++;
    if (got_q.size() != L) begin
      n_fail++;
      $display("FAIL bp_count: got %0d samples, required %0d", got_q.size(), L);
    end
    for (int k = 0; k < L && k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL bp_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_assert++;
    if ((last_pop - first_pop != L - 1) || (hold_viol != 0)) begin
      n_fail++;
      $display("FAIL bp_flow: pop span %0d (required %0d), hold violations %0d (required 0)",
               last_pop - first_pop, L - 1, hold_viol);
    end
  endtask

  task automatic test_rready_toggle();
    int s;
    fill_random();
    rr_mode = 1; or_en = 1'b1; or_rand = 1'b0;
    clear_mon();
    pulse_start(s);
    wait_idle(200, "toggle");
    model_sweep(L);
    n_assert++;
    if (got_q.size() != L) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d samples, required %0d", got_q.size(), L);
    end
    for (int k = 0; k < L && k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL toggle_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_assert++;
    if ((viol != 0) || (req_cnt != L)) begin
      n_fail++;
      $display("FAIL toggle_requests: violations %0d requests %0d, required 0 and %0d", viol, req_cnt, L);
    end
    rr_mode = 0;
  endtask

  task automatic test_random_traffic();
    int s;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      rr_mode = 2; or_en = 1'b1; or_rand = 1'b1;
      clear_mon();
      pulse_start(s);
      wait_idle(300, "random");
      model_sweep(L);
      n_assert++;
      if (got_q.size() != L) begin
        n_fail++;
        $display("FAIL random%0d_count: got %0d samples, required %0d", r, got_q.size(), L);
      end
      for (int k = 0; k < L && k < got_q.size(); k++) begin
        n_assert++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random%0d_sample%0d: got %h, required %h", r, k, got_q[k], exp_q[k]);
        end
      end
      n_assert++;
      if ((viol != 0) || (hold_viol != 0) || (overflow !== 1'b0)) begin
        n_fail++;
        $display("FAIL random%0d_protocol: violations %0d hold %0d overflow %b, required 0 0 0",
                 r, viol, hold_viol, overflow);
      end
    end
    rr_mode = 0; or_rand = 1'b0;
  endtask

  task automatic test_overflow();
    int s;
    fill_random();
    or_en = 1'b0;
    clear_mon();
    pulse_start(s);
    repeat (12) @(negedge clk);
    #2;
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before: overflow=%b, required 0", overflow);
    end
    inject = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: overflow=%b, required 1", overflow);
    end
    or_en = 1'b1;
    wait_idle(100, "ovf");
    model_sweep(L);
    n_assert++;
    if (got_q.size() != L) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d samples, required %0d", got_q.size(), L);
    end
    for (int k = 0; k < L && k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL ovf_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: overflow=%b after sweep, required 1", overflow);
    end
    do_reset();
    #2;
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: overflow=%b after reset, required 0", overflow);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int s;
    fill_random();
    or_en = 1'b1;
    clear_mon();
    pulse_start(s);
    wait_samples(5, 50, "midrst");
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, out_valid, m_axi_rvalid, m_axi_raddr} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_async: busy/valid/rvalid=%b raddr=%0d, required 0",
               {busy, out_valid, m_axi_rvalid}, m_axi_raddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    n_assert++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_stale: busy/valid=%b after release, required 00", {busy, out_valid});
    end
    clear_mon();
    pulse_start(s);
    wait_idle(100, "midrst");
    model_sweep(L);
    n_assert++;
    if ((got_q.size() != L) || (first_req_addr != 0)) begin
      n_fail++;
      $display("FAIL midrst_fresh: %0d samples from addr %0d, required %0d from 0",
               got_q.size(), first_req_addr, L);
    end
    for (int k = 0; k < L && k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL midrst_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

`ifdef REFERENCE_FETCHER_LOOP_EN
  task automatic test_loop();
    int s;
    fill_random();
    rr_mode = 0; or_en = 1'b1; or_rand = 1'b0;
    clear_mon();
    pulse_start(s);
    wait_samples(25, 200, "loop");
    pulse_start(s);
    wait_idle(100, "loop");
    model_sweep(got_q.size());
    n_assert++;
    if ((got_q.size() < 25) || (req_cnt != got_q.size())) begin
      n_fail++;
      $display("FAIL loop_count: %0d samples for %0d requests, required >=25 and equal",
               got_q.size(), req_cnt);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      n_assert++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL loop_sample%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_assert++;
    if ((viol != 0) || (overflow !== 1'b0)) begin
      n_fail++;
      $display("FAIL loop_protocol: violations %0d overflow %b, required 0 0", viol, overflow);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef REFERENCE_FETCHER_LOOP_EN
    test_loop();
`else
    test_single_sweep();
    test_backpressure();
    test_rready_toggle();
    test_random_traffic();
    test_overflow();
    test_reset_mid_sweep();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
